// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg: shared constants and FIFO entry layout for the fetch unit  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_pkg;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam logic [63:0] PC_ALIGN_MASK = ~64'(INSTR_BYTES - 1);
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  // Prefetch entries are packed {pc, instr}; pc occupies the upper bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if: instruction-memory port and decode handshake bundle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int ISTR_WIDTH = 32,
  parameter int IMEM_AW    = 9
);

  logic                  imem_rd_en;
  logic [IMEM_AW-1:0]    imem_addr;
  logic [ISTR_WIDTH-1:0] imem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [ISTR_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]   out_pc;

  modport master (
    output imem_rd_en, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, out_ready
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO with flush and occupancy count          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign full     = (r_count == c_DEPTH);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr = push && (!full || pop);
  assign w_rd = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit: sequential instruction fetch with prefetch FIFO/redirect |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int                  PC_WIDTH   = 32,
  parameter  int                  ISTR_WIDTH = 32,
  parameter  int                  IMEM_AW    = 9,
  parameter  int                  FIFO_DEPTH = 4,
  parameter  logic [PC_WIDTH-1:0] RESET_PC   = '0,
  localparam int                  CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                fetch_en,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  fetch_unit_if.master        bus,
  output logic [CW-1:0]       fifo_count
);

  localparam int                  EW           = PC_WIDTH + ISTR_WIDTH;
  localparam logic [PC_WIDTH-1:0] c_ALIGN_MASK = PC_ALIGN_MASK[PC_WIDTH-1:0];
  localparam logic [CW-1:0]       c_DEPTH      = CW'(FIFO_DEPTH);

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_req_pc;
  logic                r_pending;
  logic [CW-1:0]       w_inflight;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [EW-1:0]       w_head;

  // Credit counts the in-flight response; same-cycle pops are not credited.
  assign w_inflight = fifo_count + CW'(r_pending);
  assign w_issue    = reset_n && fetch_en && !redirect_valid && (w_inflight < c_DEPTH);
  assign w_push     = r_pending && !redirect_valid;
  assign w_pop      = bus.out_valid && bus.out_ready;

  assign bus.imem_rd_en = w_issue;
  assign bus.imem_addr  = r_pc[IMEM_AW+1:2];
  assign bus.out_valid  = !w_empty;
  assign bus.out_pc     = w_empty ? '0 : w_head[EW-1:ISTR_WIDTH];
  assign bus.out_instr  = w_empty ? '0 : w_head[ISTR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc      <= RESET_PC & c_ALIGN_MASK;
      r_req_pc  <= '0;
      r_pending <= 1'b0;
    end else if (redirect_valid) begin
      r_pc      <= redirect_pc & c_ALIGN_MASK;
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_pc     <= r_pc + PC_WIDTH'(INSTR_BYTES);
        r_req_pc <= r_pc;
      end
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data ({r_req_pc, bus.imem_rdata}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(w_push && w_full));
    end
  end

endmodule
`default_nettype wire
